// File: rtl/uart_pkg.sv
// uart_pkg: shared constants for the UART FIFO peripheral
//   register addresses, STATUS/CTRL bit positions and FSM state encoding
package uart_pkg;
    localparam logic [1:0] A_DATA   = 2'd0;
    localparam logic [1:0] A_STATUS = 2'd1;
    localparam logic [1:0] A_CTRL   = 2'd2;
    localparam logic [1:0] A_RSVD   = 2'd3;

    localparam int ST_TX_EMPTY = 0;
    localparam int ST_TX_FULL  = 1;
    localparam int ST_RX_VALID = 2;
    localparam int ST_BUSY     = 3;
    localparam int ST_TX_OVF   = 4;
    localparam int ST_RX_OVF   = 5;

    localparam int CT_RX_IE = 0;
    localparam int CT_TX_IE = 1;

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO
//   clk, rst_n : clock, async active-low reset (empties the FIFO)
//   push, din  : write request and data
//   pop, dout  : read request and current head
//   full, empty, count : occupancy
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_cnt;
    logic             w_push;
    logic             w_pop;

    // a pop frees a slot in the same cycle, so a push into a full FIFO is kept
    assign w_pop  = pop & ~empty;
    assign w_push = push & (~full | w_pop);
    assign full   = r_cnt == FULL_CNT;
    assign empty  = r_cnt == '0;
    assign count  = r_cnt;
    assign dout   = r_mem[r_rd];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + 1'b1;
            if (w_pop) r_rd <= r_rd + 1'b1;
            r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= din;
    end
endmodule

// File: rtl/uart_fifo_perif.sv
// uart_fifo_perif: bus-mapped 8N1 UART with TX and RX FIFOs
//   clk, rst_n     : clock, async active-low reset
//   CS, WE, AB, DI : one-cycle bus strobe, write enable, address, write data
//   DO             : registered read data
//   tx_pin, rx_pin : serial out (idle high), serial in (asynchronous)
//   irq            : level interrupt (rx_valid & rx_ie) | (tx_empty & tx_ie)
module uart_fifo_perif
    import uart_pkg::*;
#(
    parameter int CLK_DIV  = 235,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       CS,
    input  logic       WE,
    input  logic [1:0] AB,
    input  logic [7:0] DI,
    output logic [7:0] DO,
    output logic       tx_pin,
    input  logic       rx_pin,
    output logic       irq
);
    localparam int DW = $clog2(CLK_DIV);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [DW-1:0] HALF_LAST = DW'(CLK_DIV / 2 - 1);

    logic        w_wr, w_rd, w_tx_push, w_rx_pop, w_stat_rd;
    logic        w_tx_pop, w_tx_full, w_tx_empty, w_tx_drop, w_tx_end;
    logic        w_rx_push, w_rx_full, w_rx_empty, w_rx_drop, w_rx_samp;
    logic [7:0]  w_tx_head, w_rx_head, w_status, w_rd_data;
    logic [$clog2(TX_DEPTH):0] w_unused_tx_count;
    logic [$clog2(RX_DEPTH):0] w_unused_rx_count;

    uart_state_t r_tx_state, w_tx_next, r_rx_state, w_rx_next;
    logic [DW-1:0] r_tx_cnt, r_rx_cnt;
    logic [2:0]    r_tx_bit, r_rx_bit;
    logic [7:0]    r_tx_shift, r_rx_shift;
    logic          r_rx_s1, r_rx_s2, r_rx_prev;
    logic          r_tx_ovf, r_rx_ovf;
    logic [1:0]    r_ctrl;

    assign w_wr      = CS & WE;
    assign w_rd      = CS & ~WE;
    assign w_tx_push = w_wr & (AB == A_DATA);
    assign w_rx_pop  = w_rd & (AB == A_DATA);
    assign w_stat_rd = w_rd & (AB == A_STATUS);
    // a drop only happens when no pop makes room in the same cycle
    assign w_tx_drop = w_tx_push & w_tx_full & ~w_tx_pop;
    assign w_rx_drop = w_rx_push & w_rx_full & ~w_rx_pop;

    sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(w_tx_push), .pop(w_tx_pop), .din(DI),
        .dout(w_tx_head), .full(w_tx_full), .empty(w_tx_empty), .count(w_unused_tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(w_rx_push), .pop(w_rx_pop), .din(r_rx_shift),
        .dout(w_rx_head), .full(w_rx_full), .empty(w_rx_empty), .count(w_unused_rx_count)
    );

    assign w_tx_end = r_tx_cnt == DIV_LAST;

    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_pop  = 1'b0;
        case (r_tx_state)
            S_IDLE: begin
                w_tx_next = w_tx_empty ? S_IDLE : S_START;
                w_tx_pop  = ~w_tx_empty;
            end
            S_START: w_tx_next = w_tx_end ? S_DATA : S_START;
            S_DATA:  w_tx_next = (w_tx_end && r_tx_bit == 3'd7) ? S_STOP : S_DATA;
            S_STOP: begin
                if (w_tx_end) begin
                    w_tx_next = w_tx_empty ? S_IDLE : S_START;
                    w_tx_pop  = ~w_tx_empty;
                end
            end
            default: w_tx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_state <= S_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
        end else begin
            r_tx_state <= w_tx_next;
            r_tx_cnt   <= (r_tx_state == S_IDLE || w_tx_end) ? '0 : r_tx_cnt + 1'b1;
            if (w_tx_pop) r_tx_shift <= w_tx_head;
            else if (r_tx_state == S_DATA && w_tx_end) r_tx_shift <= {1'b1, r_tx_shift[7:1]};
            if (r_tx_state == S_DATA && w_tx_end) r_tx_bit <= r_tx_bit + 1'b1;
        end
    end

    // decoded from state so the async reset forces the line high at once
    assign tx_pin = (r_tx_state == S_START) ? 1'b0 : (r_tx_state == S_DATA) ? r_tx_shift[0] : 1'b1;

    // the start bit is checked half a bit in; every later sample is one bit further
    assign w_rx_samp = r_rx_cnt == ((r_rx_state == S_START) ? HALF_LAST : DIV_LAST);

    always_comb begin
        w_rx_next = r_rx_state;
        w_rx_push = 1'b0;
        case (r_rx_state)
            S_IDLE:  w_rx_next = (r_rx_prev & ~r_rx_s2) ? S_START : S_IDLE;
            S_START: w_rx_next = w_rx_samp ? (r_rx_s2 ? S_IDLE : S_DATA) : S_START;
            S_DATA:  w_rx_next = (w_rx_samp && r_rx_bit == 3'd7) ? S_STOP : S_DATA;
            S_STOP: begin
                w_rx_next = w_rx_samp ? S_IDLE : S_STOP;
                w_rx_push = w_rx_samp & r_rx_s2;
            end
            default: w_rx_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_s1    <= 1'b1;
            r_rx_s2    <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_state <= S_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
        end else begin
            r_rx_s1    <= rx_pin;
            r_rx_s2    <= r_rx_s1;
            r_rx_prev  <= r_rx_s2;
            r_rx_state <= w_rx_next;
            r_rx_cnt   <= (r_rx_state == S_IDLE || w_rx_samp) ? '0 : r_rx_cnt + 1'b1;
            if (r_rx_state == S_DATA && w_rx_samp) begin
                r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                r_rx_bit   <= r_rx_bit + 1'b1;
            end
        end
    end

    always_comb begin
        w_status              = '0;
        w_status[ST_TX_EMPTY] = w_tx_empty;
        w_status[ST_TX_FULL]  = w_tx_full;
        w_status[ST_RX_VALID] = ~w_rx_empty;
        w_status[ST_BUSY]     = r_tx_state != S_IDLE;
        w_status[ST_TX_OVF]   = r_tx_ovf;
        w_status[ST_RX_OVF]   = r_rx_ovf;
    end

    assign w_rd_data = (AB == A_DATA)   ? (w_rx_empty ? 8'h00 : w_rx_head) :
                       (AB == A_STATUS) ? w_status :
                       (AB == A_CTRL)   ? {6'b0, r_ctrl} : 8'h00;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            DO       <= '0;
            r_ctrl   <= '0;
            r_tx_ovf <= 1'b0;
            r_rx_ovf <= 1'b0;
        end else begin
            if (w_rd) DO <= w_rd_data;
            if (w_wr && AB == A_CTRL) r_ctrl <= DI[1:0];
            // a new overflow in the cycle of a STATUS read stays visible
            r_tx_ovf <= w_tx_drop | (r_tx_ovf & ~w_stat_rd);
            r_rx_ovf <= w_rx_drop | (r_rx_ovf & ~w_stat_rd);
        end
    end

    assign irq = (~w_rx_empty & r_ctrl[CT_RX_IE]) | (w_tx_empty & r_ctrl[CT_TX_IE]);
endmodule

// File: tb/tb_uart_fifo_perif.sv
// tb_uart_fifo_perif: directed self-checking bench for uart_fifo_perif at CLK_DIV=16
module tb_uart_fifo_perif;
    logic       clk = 1'b0;
    logic       rst_n, CS, WE, tx_pin, rx_pin, irq;
    logic [1:0] AB;
    logic [7:0] DI, DO;
    int         checks = 0;
    int         fails = 0;
    int         cyc = 0;
    int         last_start = 0;
    logic [7:0] mq[$];
    logic       ms[$];
    int         mt[$];

    typedef struct {
        logic       we;
        logic [1:0] ab;
        logic [7:0] di;
        logic [7:0] exp_do;
        logic       exp_irq;
    } vec_t;
    vec_t vt[12];

    uart_fifo_perif #(.CLK_DIV(16), .TX_DEPTH(8), .RX_DEPTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .CS(CS), .WE(WE), .AB(AB), .DI(DI), .DO(DO),
        .tx_pin(tx_pin), .rx_pin(rx_pin), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic bus(input logic we, input logic [1:0] ab, input logic [7:0] di);
        @(negedge clk);
        CS = 1'b1; WE = we; AB = ab; DI = di;
        @(negedge clk);
        CS = 1'b0;
    endtask

    task automatic wr(input logic [1:0] ab, input logic [7:0] di);
        bus(1'b1, ab, di);
    endtask

    task automatic rd_chk(input logic [1:0] ab, input logic [7:0] exp, input string nm);
        bus(1'b0, ab, 8'h00);
        chk(nm, DO, exp);
    endtask

    task automatic wait_fall(input string nm);
        int t = 0;
        while (tx_pin !== 1'b0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        chk(nm, tx_pin, 1'b0);
    endtask

    task automatic wait_q(input int n, input int lim, input string nm);
        int t = 0;
        while (mq.size() < n && t < lim) begin
            @(negedge clk);
            t++;
        end
        chk(nm, mq.size(), n);
    endtask

    task automatic clr_q();
        mq.delete(); ms.delete(); mt.delete();
    endtask

    task automatic send_rx(input logic [7:0] b, input logic sb);
        @(negedge clk);
        rx_pin = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_pin = b[i];
            repeat (16) @(negedge clk);
        end
        rx_pin = sb;
        repeat (16) @(negedge clk);
        rx_pin = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    // serial decoder for tx_pin: samples each bit at its centre
    initial begin : mon
        int t0;
        logic [7:0] b;
        forever begin
            @(negedge clk);
            if (rst_n === 1'b1 && tx_pin === 1'b0) begin
                t0 = cyc;
                last_start = cyc;
                repeat (8) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (16) @(negedge clk);
                    b[i] = tx_pin;
                end
                repeat (16) @(negedge clk);
                mq.push_back(b); ms.push_back(tx_pin); mt.push_back(t0);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1);
    end

    initial begin
        logic [7:0] exp55;
        logic [7:0] rxb[5];
        int bad, zeros, t;
        vt[0]  = '{1'b0, 2'd1, 8'h00, 8'h01, 1'b0};
        vt[1]  = '{1'b0, 2'd2, 8'h00, 8'h00, 1'b0};
        vt[2]  = '{1'b0, 2'd0, 8'h00, 8'h00, 1'b0};
        vt[3]  = '{1'b0, 2'd3, 8'h00, 8'h00, 1'b0};
        vt[4]  = '{1'b1, 2'd2, 8'hFF, 8'h00, 1'b1};
        vt[5]  = '{1'b0, 2'd2, 8'h00, 8'h03, 1'b1};
        vt[6]  = '{1'b1, 2'd3, 8'h5A, 8'h03, 1'b1};
        vt[7]  = '{1'b0, 2'd3, 8'h00, 8'h00, 1'b1};
        vt[8]  = '{1'b1, 2'd2, 8'h01, 8'h00, 1'b0};
        vt[9]  = '{1'b0, 2'd2, 8'h00, 8'h01, 1'b0};
        vt[10] = '{1'b1, 2'd2, 8'h00, 8'h01, 1'b0};
        vt[11] = '{1'b0, 2'd2, 8'h00, 8'h00, 1'b0};
        rxb = '{8'h3C, 8'hC3, 8'h5A, 8'h96, 8'h7E};

        rst_n = 1'b0; CS = 1'b0; WE = 1'b0; AB = 2'd0; DI = 8'h00; rx_pin = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_do", DO, 8'h00);
        chk("reset_tx_pin", tx_pin, 1'b1);
        chk("reset_irq", irq, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < 12; i++) begin
            bus(vt[i].we, vt[i].ab, vt[i].di);
            chk($sformatf("vec%0d_do", i), DO, vt[i].exp_do);
            chk($sformatf("vec%0d_irq", i), irq, vt[i].exp_irq);
        end

        // single 0x55 frame, every cycle of every bit checked
        exp55 = 8'h55;
        wr(2'd0, 8'h55);
        wait_fall("t1_start");
        for (int b = 0; b < 10; b++) begin
            bad = 0;
            for (int k = 0; k < 16; k++) begin
                if (tx_pin !== ((b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp55[b-1])) bad++;
                @(negedge clk);
            end
            chk($sformatf("t1_bit%0d_bad_cycles", b), bad, 0);
        end
        rd_chk(2'd1, 8'h01, "t1_status_idle");

        // three back-to-back frames
        clr_q();
        wr(2'd0, 8'h01); wr(2'd0, 8'h02); wr(2'd0, 8'h03);
        rd_chk(2'd1, 8'h08, "t2_status_busy");
        wait_q(3, 700, "t2_frames");
        if (mq.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("t2_byte%0d", i), mq[i], 8'(i + 1));
                chk($sformatf("t2_stop%0d", i), ms[i], 1'b1);
            end
            chk("t2_gap01", mt[1] - mt[0], 160);
            chk("t2_gap12", mt[2] - mt[1], 160);
        end
        repeat (12) @(negedge clk);
        rd_chk(2'd1, 8'h01, "t2_status_done");

        // TX overflow, then a push coinciding with a pop while full
        clr_q();
        for (int i = 0; i < 9; i++) wr(2'd0, 8'(8'h10 + i));
        wr(2'd0, 8'hEE);
        rd_chk(2'd1, 8'h1A, "t3_status_ovf");
        rd_chk(2'd1, 8'h0A, "t3_status_cleared");
        t = 0;
        while (cyc != last_start + 159 && t < 400) begin
            @(negedge clk);
            t++;
        end
        chk("t3_align", t < 400, 1'b1);
        CS = 1'b1; WE = 1'b1; AB = 2'd0; DI = 8'h19;
        @(negedge clk);
        CS = 1'b0;
        rd_chk(2'd1, 8'h0A, "t3_status_push_pop");
        wait_q(10, 2000, "t3_frames");
        if (mq.size() == 10)
            for (int i = 0; i < 10; i++) chk($sformatf("t3_byte%0d", i), mq[i], 8'(8'h10 + i));
        repeat (12) @(negedge clk);
        rd_chk(2'd1, 8'h01, "t3_status_done");

        // receive 0xA3 with rx_ie
        wr(2'd2, 8'h01);
        chk("t4_irq_before", irq, 1'b0);
        send_rx(8'hA3, 1'b1);
        rd_chk(2'd1, 8'h05, "t4_status_valid");
        chk("t4_irq_set", irq, 1'b1);
        rd_chk(2'd0, 8'hA3, "t4_data");
        rd_chk(2'd1, 8'h01, "t4_status_empty");
        chk("t4_irq_clear", irq, 1'b0);

        // glitch and framing error
        @(negedge clk);
        rx_pin = 1'b0;
        repeat (4) @(negedge clk);
        rx_pin = 1'b1;
        repeat (40) @(negedge clk);
        rd_chk(2'd1, 8'h01, "t5_glitch_status");
        send_rx(8'h5A, 1'b0);
        rd_chk(2'd1, 8'h01, "t5_frame_err_status");
        rd_chk(2'd0, 8'h00, "t5_data_empty");

        // RX overflow: fifth byte dropped
        for (int i = 0; i < 5; i++) send_rx(rxb[i], 1'b1);
        rd_chk(2'd1, 8'h25, "t6_status_ovf");
        rd_chk(2'd1, 8'h05, "t6_status_cleared");
        for (int i = 0; i < 4; i++) rd_chk(2'd0, rxb[i], $sformatf("t6_data%0d", i));
        rd_chk(2'd0, 8'h00, "t6_data_empty");
        rd_chk(2'd1, 8'h01, "t6_status_end");

        // reset in the middle of bit 3
        wr(2'd2, 8'h02);
        wr(2'd0, 8'h55);
        wait_fall("t7_start");
        wr(2'd0, 8'h11);
        wr(2'd0, 8'h22);
        repeat (68) @(negedge clk);
        chk("t7_bit3_low", tx_pin, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("t7_tx_pin_async", tx_pin, 1'b1);
        repeat (3) @(negedge clk);
        chk("t7_do_reset", DO, 8'h00);
        rst_n = 1'b1;
        chk("t7_irq", irq, 1'b0);
        rd_chk(2'd1, 8'h01, "t7_status");
        rd_chk(2'd2, 8'h00, "t7_ctrl");
        zeros = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (tx_pin !== 1'b1) zeros++;
        end
        chk("t7_no_tx_after_reset", zeros, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule
